// File: rtl/main_function_param_if.sv
// Start/finish job interface for main_function_param.
// Optional cycles port exists only with MAIN_FUNCTION_CYCLE_COUNT_EN.
interface main_function_param_if #(
  parameter int WIDTH = 8
);
  logic               enable;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               finish;
  logic [3*WIDTH-1:0] result;
`ifdef MAIN_FUNCTION_CYCLE_COUNT_EN
  logic [15:0]        cycles;
`endif

  modport master (
    output enable, op, a, b,
    input  busy, finish, result
`ifdef MAIN_FUNCTION_CYCLE_COUNT_EN
    , input cycles
`endif
  );

  modport slave (
    input  enable, op, a, b,
    output busy, finish, result
`ifdef MAIN_FUNCTION_CYCLE_COUNT_EN
    , output cycles
`endif
  );
endinterface

// File: rtl/main_function_param.sv
// Multi-cycle a*b / a*a*b / isqrt(a) unit on one shift-add datapath.
// Macro MAIN_FUNCTION_CYCLE_COUNT_EN adds a saturating busy-cycle counter.
module main_function_param #(
  parameter int WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  main_function_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int RW = 3 * WIDTH;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_SQMUL = 2'b01;
  localparam logic [1:0] OP_ISQRT = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    MUL2,
    SQRT,
    DONE
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [RW-1:0]    mcand;
  logic [RW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             finish;
  logic [RW-1:0]    result;

  logic             start;
  logic             last_mul;
  logic             last_sqrt;
  logic [RW-1:0]    acc_add;
  logic [RW-1:0]    rem_sh;
  logic [RW-1:0]    trial;
  logic             ge;
  logic [RW-1:0]    rem_nxt;
  logic [RW-1:0]    root_nxt;

  assign start = bus.enable
    && (state == IDLE || state == DONE);

  assign last_mul  = cnt == CW'(WIDTH - 1);
  assign last_sqrt = cnt == CW'(WIDTH / 2 - 1);

  assign acc_add = acc
    + (mplier[0] ? mcand : '0);

  // In SQRT: acc = remainder, mcand = root,
  // mplier = radicand shifted out MSB first.
  assign rem_sh = {acc[RW-3:0],
                   mplier[WIDTH-1:WIDTH-2]};
  assign trial  = {mcand[RW-3:0], 2'b01};
  assign ge     = rem_sh >= trial;
  assign rem_nxt  = ge ? rem_sh - trial : rem_sh;
  assign root_nxt = {mcand[RW-2:0], ge};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= '0;
      b_q    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      result <= '0;
    end else if (start) begin
      op_q   <= bus.op;
      b_q    <= bus.b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
      finish <= 1'b0;
      unique case (1'b1)
        bus.op == OP_ISQRT: begin
          state  <= SQRT;
          mcand  <= '0;
          mplier <= bus.a;
        end
        bus.op == OP_SQMUL: begin
          state  <= MUL1;
          mcand  <= RW'(bus.a);
          mplier <= bus.a;
        end
        default: begin
          state  <= MUL1;
          mcand  <= RW'(bus.a);
          mplier <= bus.b;
        end
      endcase
    end else begin
      unique case (state)
        MUL1: begin
          if (op_q == OP_RSV) begin
            state  <= DONE;
            result <= '0;
            busy   <= 1'b0;
            finish <= 1'b1;
          end else begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_mul) begin
              if (op_q == OP_SQMUL) begin
                state  <= MUL2;
                mcand  <= acc_add;
                mplier <= b_q;
                acc    <= '0;
                cnt    <= '0;
              end else begin
                state  <= DONE;
                result <= acc_add;
                busy   <= 1'b0;
                finish <= 1'b1;
              end
            end
          end
        end
        MUL2: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_mul) begin
            state  <= DONE;
            result <= acc_add;
            busy   <= 1'b0;
            finish <= 1'b1;
          end
        end
        SQRT: begin
          acc    <= rem_nxt;
          mcand  <= root_nxt;
          mplier <= mplier << 2;
          cnt    <= cnt + 1'b1;
          if (last_sqrt) begin
            state  <= DONE;
            result <= root_nxt;
            busy   <= 1'b0;
            finish <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.finish = finish;
  assign bus.result = result;

`ifdef MAIN_FUNCTION_CYCLE_COUNT_EN
  logic [15:0] cycles;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycles <= '0;
    end else if (start) begin
      cycles <= '0;
    end else if (busy && cycles != 16'hFFFF) begin
      cycles <= cycles + 16'd1;
    end
  end

  assign bus.cycles = cycles;
`endif
endmodule

// File: tb/tb_main_function_param.sv
// Randomised self-checking bench for main_function_param, WIDTH 8 and 16.
module tb_main_function_param;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  main_function_param_if #(.WIDTH(8))  b8 ();
  main_function_param_if #(.WIDTH(16)) b16 ();

  main_function_param #(.WIDTH(8)) dut8 (
    .clock (clk),
    .reset (rst),
    .bus   (b8.slave)
  );

  main_function_param #(.WIDTH(16)) dut16 (
    .clock (clk),
    .reset (rst),
    .bus   (b16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned model(
    input int op, input longint unsigned x,
    input longint unsigned y);
    longint unsigned r;
    case (op)
      0: model = x * y;
      1: model = x * x * y;
      2: begin
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        model = r;
      end
      default: model = 0;
    endcase
  endfunction

  function automatic int latency(input int op, input int w);
    case (op)
      0: latency = w;
      1: latency = 2 * w;
      2: latency = w / 2;
      default: latency = 1;
    endcase
  endfunction

  task automatic run8(input logic [1:0] o,
    input logic [7:0] x, input logic [7:0] y,
    output logic [23:0] r, output int lat);
    @(negedge clk);
    b8.enable = 1'b1; b8.op = o; b8.a = x; b8.b = y;
    @(negedge clk);
    b8.enable = 1'b0;
    lat = 0;
    while (!b8.finish && lat < 100) begin
      @(negedge clk); lat++;
    end
    r = b8.result;
  endtask

  task automatic run16(input logic [1:0] o,
    input logic [15:0] x, input logic [15:0] y,
    output logic [47:0] r, output int lat);
    @(negedge clk);
    b16.enable = 1'b1; b16.op = o; b16.a = x; b16.b = y;
    @(negedge clk);
    b16.enable = 1'b0;
    lat = 0;
    while (!b16.finish && lat < 200) begin
      @(negedge clk); lat++;
    end
    r = b16.result;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (b8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b want 0", b8.busy);
    end
    vectors++;
    if (b8.finish !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_finish got %b want 0", b8.finish);
    end
    vectors++;
    if (b8.result !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_result got %0d want 0", b8.result);
    end
    rst = 1'b1;
  endtask

  task automatic test_mul();
    logic [23:0] r;
    int lat;
    run8(2'b00, 8'd123, 8'd33, r, lat);
    vectors++;
    if (r !== 24'd4059 || lat != 8) begin
      miscompares++;
      $display("FAIL mul got %0d lat %0d want 4059 lat 8", r, lat);
    end
`ifdef MAIN_FUNCTION_CYCLE_COUNT_EN
    vectors++;
    if (b8.cycles !== 16'd8) begin
      miscompares++;
      $display("FAIL mul_cycles got %0d want 8", b8.cycles);
    end
`endif
  endtask

  task automatic test_sqmul();
    logic [23:0] r;
    int lat;
    run8(2'b01, 8'd123, 8'd33, r, lat);
    vectors++;
    if (r !== 24'd499257 || lat != 16) begin
      miscompares++;
      $display("FAIL sqmul got %0d lat %0d want 499257 lat 16", r, lat);
    end
    run8(2'b01, 8'd255, 8'd255, r, lat);
    vectors++;
    if (r !== 24'd16581375 || lat != 16) begin
      miscompares++;
      $display("FAIL sqmul_max got %0d lat %0d want 16581375 lat 16",
        r, lat);
    end
  endtask

  task automatic test_isqrt();
    logic [23:0] r;
    int lat;
    int xs[4] = '{255, 0, 144, 143};
    int ex[4] = '{15, 0, 12, 11};
    for (int i = 0; i < 4; i++) begin
      run8(2'b10, 8'(xs[i]), 8'($urandom), r, lat);
      vectors++;
      if (r !== 24'(ex[i]) || lat != 4) begin
        miscompares++;
        $display("FAIL isqrt a=%0d got %0d lat %0d want %0d lat 4",
          xs[i], r, lat, ex[i]);
      end
    end
  endtask

  task automatic test_reserved();
    logic [23:0] r;
    int lat;
    run8(2'b11, 8'd77, 8'd88, r, lat);
    vectors++;
    if (r !== 24'd0 || lat != 1) begin
      miscompares++;
      $display("FAIL reserved got %0d lat %0d want 0 lat 1", r, lat);
    end
  endtask

  task automatic test_ignore_enable();
    int lat;
    @(negedge clk);
    b8.enable = 1'b1; b8.op = 2'b00; b8.a = 8'd123; b8.b = 8'd33;
    @(negedge clk);
    b8.enable = 1'b0;
    lat = 0;
    while (!b8.finish && lat < 100) begin
      if (lat == 2) begin
        b8.enable = 1'b1; b8.a = 8'd1; b8.b = 8'd1;
      end else begin
        b8.enable = 1'b0;
      end
      @(negedge clk); lat++;
    end
    b8.enable = 1'b0;
    vectors++;
    if (b8.result !== 24'd4059 || lat != 8) begin
      miscompares++;
      $display("FAIL ignore_enable got %0d lat %0d want 4059 lat 8",
        b8.result, lat);
    end
  endtask

  task automatic test_midjob_reset();
    logic [23:0] r;
    int lat;
    @(negedge clk);
    b8.enable = 1'b1; b8.op = 2'b01; b8.a = 8'd123; b8.b = 8'd33;
    @(negedge clk);
    b8.enable = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    vectors++;
    if (b8.busy !== 1'b0 || b8.finish !== 1'b0
        || b8.result !== 24'd0) begin
      miscompares++;
      $display("FAIL midjob_reset got busy %b finish %b result %0d want 0 0 0",
        b8.busy, b8.finish, b8.result);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (b8.finish !== 1'b0 || b8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL discarded_job got busy %b finish %b want 0 0",
        b8.busy, b8.finish);
    end
    run8(2'b00, 8'd2, 8'd3, r, lat);
    vectors++;
    if (r !== 24'd6 || lat != 8) begin
      miscompares++;
      $display("FAIL after_reset got %0d lat %0d want 6 lat 8", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] r;
    int lat;
    run8(2'b00, 8'd200, 8'd250, r, lat);
    vectors++;
    if (r !== 24'd50000) begin
      miscompares++;
      $display("FAIL b2b_first got %0d want 50000", r);
    end
    @(negedge clk);
    b8.enable = 1'b1; b8.op = 2'b01; b8.a = 8'd7; b8.b = 8'd9;
    @(negedge clk);
    b8.enable = 1'b0;
    vectors++;
    if (b8.busy !== 1'b1 || b8.finish !== 1'b0
        || b8.result !== 24'd50000) begin
      miscompares++;
      $display("FAIL b2b_start got busy %b finish %b result %0d want 1 0 50000",
        b8.busy, b8.finish, b8.result);
    end
    lat = 0;
    while (!b8.finish && lat < 100) begin
      @(negedge clk); lat++;
    end
    vectors++;
    if (b8.result !== 24'd441 || lat != 16) begin
      miscompares++;
      $display("FAIL b2b_second got %0d lat %0d want 441 lat 16",
        b8.result, lat);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (b8.finish !== 1'b1 || b8.result !== 24'd441) begin
      miscompares++;
      $display("FAIL done_hold got finish %b result %0d want 1 441",
        b8.finish, b8.result);
    end
  endtask

  task automatic test_random();
    logic [23:0] r;
    logic [7:0] x;
    logic [7:0] y;
    int op;
    int lat;
    longint unsigned exp;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      x = 8'($urandom);
      y = 8'($urandom);
      run8(2'(op), x, y, r, lat);
      exp = model(op, longint'(x), longint'(y));
      vectors++;
      if (r !== 24'(exp) || lat != latency(op, 8)) begin
        miscompares++;
        $display("FAIL random op %0d a %0d b %0d got %0d lat %0d want %0d lat %0d",
          op, x, y, r, lat, exp, latency(op, 8));
      end
    end
  endtask

  task automatic test_width16();
    logic [47:0] r;
    logic [15:0] x;
    logic [15:0] y;
    int op;
    int lat;
    longint unsigned exp;
    run16(2'b01, 16'hFFFF, 16'hFFFF, r, lat);
    exp = model(1, 65535, 65535);
    vectors++;
    if (r !== 48'(exp) || lat != 32) begin
      miscompares++;
      $display("FAIL w16_sqmul_max got %0d lat %0d want %0d lat 32",
        r, lat, exp);
    end
`ifdef MAIN_FUNCTION_CYCLE_COUNT_EN
    vectors++;
    if (b16.cycles !== 16'd32) begin
      miscompares++;
      $display("FAIL w16_cycles got %0d want 32", b16.cycles);
    end
`endif
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 3);
      x = 16'($urandom);
      y = 16'($urandom);
      run16(2'(op), x, y, r, lat);
      exp = model(op, longint'(x), longint'(y));
      vectors++;
      if (r !== 48'(exp) || lat != latency(op, 16)) begin
        miscompares++;
        $display("FAIL w16_random op %0d a %0d b %0d got %0d lat %0d want %0d",
          op, x, y, r, lat, exp);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    b8.enable = 1'b0;  b8.op = '0;  b8.a = '0;  b8.b = '0;
    b16.enable = 1'b0; b16.op = '0; b16.a = '0; b16.b = '0;
    test_reset();
    test_mul();
    test_sqmul();
    test_isqrt();
    test_reserved();
    test_ignore_enable();
    test_midjob_reset();
    test_back_to_back();
    test_random();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end
endmodule
